// File: rtl/axi_lite_wr_arbiter.sv
// N-master to 1-slave AXI4-Lite write-path arbiter: round-robin on AW valid,
// one outstanding write, AW/W forwarded independently, B routed to the owner only.
module axi_lite_wr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_aw_addr,
    input  logic [NUM_MASTERS-1:0]            s_aw_valid,
    output logic [NUM_MASTERS-1:0]            s_aw_ready,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_w_data,
    input  logic [NUM_MASTERS*STRB_WIDTH-1:0] s_w_strb,
    input  logic [NUM_MASTERS-1:0]            s_w_valid,
    output logic [NUM_MASTERS-1:0]            s_w_ready,
    output logic [1:0]                        s_b_resp,
    output logic [NUM_MASTERS-1:0]            s_b_valid,
    input  logic [NUM_MASTERS-1:0]            s_b_ready,
    output logic [ADDR_WIDTH-1:0]             m_aw_addr,
    output logic                              m_aw_valid,
    input  logic                              m_aw_ready,
    output logic [DATA_WIDTH-1:0]             m_w_data,
    output logic [STRB_WIDTH-1:0]             m_w_strb,
    output logic                              m_w_valid,
    input  logic                              m_w_ready,
    input  logic [1:0]                        m_b_resp,
    input  logic                              m_b_valid,
    output logic                              m_b_ready,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic [1:0]                        o_dbg_state
);

    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [GW-1:0]          r_gidx;
    logic [GW-1:0]          r_last;
    logic                   r_aw_done;
    logic                   r_w_done;

    logic          w_hi_found;
    logic          w_lo_found;
    logic [GW-1:0] w_hi_idx;
    logic [GW-1:0] w_lo_idx;
    logic          w_pick_valid;
    logic [GW-1:0] w_pick_idx;
    logic          w_in_xfer;
    logic          w_in_resp;
    logic          w_sel_aw_valid;
    logic          w_sel_w_valid;
    logic          w_sel_b_ready;
    logic          w_aw_hs;
    logic          w_w_hs;
    logic          w_b_hs;
    logic          w_both_done;

    // Round-robin: first requester above the last owner wins, else the lowest requester.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (s_aw_valid[j] && !w_hi_found && (GW'(j) > r_last)) begin
                w_hi_found = 1'b1;
                w_hi_idx   = GW'(j);
            end
            if (s_aw_valid[j] && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_idx   = GW'(j);
            end
        end
    end

    assign w_pick_valid = w_hi_found | w_lo_found;
    assign w_pick_idx   = w_hi_found ? w_hi_idx : w_lo_idx;

    // Payload mux is an AND-OR on the one-hot grant, so it reads zero whenever nobody owns the bus.
    always_comb begin
        m_aw_addr = '0;
        m_w_data  = '0;
        m_w_strb  = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (r_grant[j]) begin
                m_aw_addr = s_aw_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                m_w_data  = s_w_data[j*DATA_WIDTH +: DATA_WIDTH];
                m_w_strb  = s_w_strb[j*STRB_WIDTH +: STRB_WIDTH];
            end
        end
    end

    assign w_in_xfer      = (r_state == ST_XFER);
    assign w_in_resp      = (r_state == ST_RESP);
    assign w_sel_aw_valid = |(s_aw_valid & r_grant);
    assign w_sel_w_valid  = |(s_w_valid & r_grant);
    assign w_sel_b_ready  = |(s_b_ready & r_grant);

    // A channel transfers on a cycle where valid and ready are both high at the rising edge;
    // ready is combinational from the far side, and each channel transfers once per write.
    assign m_aw_valid = w_in_xfer & w_sel_aw_valid & ~r_aw_done;
    assign m_w_valid  = w_in_xfer & w_sel_w_valid & ~r_w_done;
    assign s_aw_ready = (w_in_xfer & m_aw_ready & ~r_aw_done) ? r_grant : '0;
    assign s_w_ready  = (w_in_xfer & m_w_ready & ~r_w_done) ? r_grant : '0;
    assign m_b_ready  = w_in_resp & w_sel_b_ready;
    assign s_b_valid  = (w_in_resp & m_b_valid) ? r_grant : '0;
    assign s_b_resp   = (|r_grant) ? m_b_resp : 2'b00;

    assign w_aw_hs     = m_aw_valid & m_aw_ready;
    assign w_w_hs      = m_w_valid & m_w_ready;
    assign w_b_hs      = m_b_valid & m_b_ready;
    assign w_both_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

    assign grant       = r_grant;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_last    <= GW'(NUM_MASTERS - 1);
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= NUM_MASTERS'(1) << w_pick_idx;
                        r_gidx  <= w_pick_idx;
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_done <= 1'b1;
                    end
                    if (w_both_done) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_b_hs) begin
                        r_state   <= ST_IDLE;
                        r_last    <= r_gidx;
                        r_grant   <= '0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_grant   <= '0;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_wr_arbiter.sv
// Bench for axi_lite_wr_arbiter: directed protocol scenarios followed by randomized
// batches checked against a queue-based round-robin reference model.
module tb_axi_lite_wr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int RW = 8 + AW + DW + SW + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N*AW-1:0] s_aw_addr;
    logic [N-1:0]    s_aw_valid;
    logic [N-1:0]    s_aw_ready;
    logic [N*DW-1:0] s_w_data;
    logic [N*SW-1:0] s_w_strb;
    logic [N-1:0]    s_w_valid;
    logic [N-1:0]    s_w_ready;
    logic [1:0]      s_b_resp;
    logic [N-1:0]    s_b_valid;
    logic [N-1:0]    s_b_ready;
    logic [AW-1:0]   m_aw_addr;
    logic            m_aw_valid;
    logic            m_aw_ready;
    logic [DW-1:0]   m_w_data;
    logic [SW-1:0]   m_w_strb;
    logic            m_w_valid;
    logic            m_w_ready;
    logic [1:0]      m_b_resp;
    logic            m_b_valid;
    logic            m_b_ready;
    logic [N-1:0]    grant;
    logic [1:0]      dbg_state;

    logic [AW-1:0] ma_addr [N];
    logic [DW-1:0] ma_data [N];
    logic [SW-1:0] ma_strb [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            s_aw_addr[i*AW +: AW] = ma_addr[i];
            s_w_data[i*DW +: DW]  = ma_data[i];
            s_w_strb[i*SW +: SW]  = ma_strb[i];
        end
    end

    axi_lite_wr_arbiter #(
        .NUM_MASTERS(N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .STRB_WIDTH (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_aw_addr  (s_aw_addr),
        .s_aw_valid (s_aw_valid),
        .s_aw_ready (s_aw_ready),
        .s_w_data   (s_w_data),
        .s_w_strb   (s_w_strb),
        .s_w_valid  (s_w_valid),
        .s_w_ready  (s_w_ready),
        .s_b_resp   (s_b_resp),
        .s_b_valid  (s_b_valid),
        .s_b_ready  (s_b_ready),
        .m_aw_addr  (m_aw_addr),
        .m_aw_valid (m_aw_valid),
        .m_aw_ready (m_aw_ready),
        .m_w_data   (m_w_data),
        .m_w_strb   (m_w_strb),
        .m_w_valid  (m_w_valid),
        .m_w_ready  (m_w_ready),
        .m_b_resp   (m_b_resp),
        .m_b_valid  (m_b_valid),
        .m_b_ready  (m_b_ready),
        .grant      (grant),
        .o_dbg_state(dbg_state)
    );

    int tests = 0;
    int fails = 0;

    // slave-side handshake counters
    int n_aw_hs = 0;
    int n_w_hs  = 0;
    always @(posedge clk) begin
        if (m_aw_valid && m_aw_ready) n_aw_hs <= n_aw_hs + 1;
        if (m_w_valid && m_w_ready) n_w_hs <= n_w_hs + 1;
    end

    // scoreboard and random-phase state
    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] exp_rec;
    logic [N-1:0]  rmask, rpend, rdone, hs_aw, hs_w, hs_b;
    int            wwait [N];
    int            mlast, rj, cycles, aw0, w0;
    bit            sl_aw, sl_w, mhs_b;
    int            sl_dly;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_data;
    logic [SW-1:0] cap_strb;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int m);
        logic [N-1:0] v;
        v    = '0;
        v[m] = 1'b1;
        return v;
    endfunction

    function automatic logic [RW-1:0] make_rec(input int j);
        return {8'(j), ma_addr[j], ma_data[j], ma_strb[j], ma_addr[j][5:4]};
    endfunction

    task automatic raise(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        ma_addr[m]    = a;
        ma_data[m]    = d;
        ma_strb[m]    = s;
        s_aw_valid[m] = 1'b1;
        s_w_valid[m]  = 1'b1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        s_aw_valid = '0;
        s_w_valid  = '0;
        s_b_ready  = '0;
        m_aw_ready = 1'b0;
        m_w_ready  = 1'b0;
        m_b_valid  = 1'b0;
        m_b_resp   = 2'b00;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // One complete write by master m with an always-ready slave; m must win the next arbitration.
    task automatic serve(input int m, input logic [1:0] resp, input bit rearm);
        cyc();
        settle();
        check("serve_grant", grant, oh(m));
        check("serve_aw_addr", m_aw_addr, ma_addr[m]);
        check("serve_w_data", m_w_data, ma_data[m]);
        check("serve_w_strb", m_w_strb, ma_strb[m]);
        check("serve_aw_ready", s_aw_ready, oh(m));
        check("serve_fwd_valids", {m_aw_valid, m_w_valid, m_b_ready}, 3'b110);
        cyc();
        s_aw_valid[m] = 1'b0;
        s_w_valid[m]  = 1'b0;
        m_b_valid     = 1'b1;
        m_b_resp      = resp;
        s_b_ready     = oh(m);
        settle();
        check("serve_b_valid", s_b_valid, oh(m));
        check("serve_b_resp", s_b_resp, resp);
        check("serve_m_b_ready", m_b_ready, 1'b1);
        cyc();
        m_b_valid = 1'b0;
        s_b_ready = '0;
        if (rearm) raise(m, $urandom & 32'hFFFF_FFFC, $urandom, SW'($urandom_range(1, 15)));
        settle();
        check("serve_release", grant, '0);
    endtask

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            ma_addr[i] = '0;
            ma_data[i] = '0;
            ma_strb[i] = '0;
        end

        // Reset state, with a request and a busy-looking slave present during reset
        do_reset();
        rst        = 1'b1;
        m_aw_ready = 1'b1;
        m_w_ready  = 1'b1;
        m_b_valid  = 1'b1;
        m_b_resp   = 2'b11;
        raise(0, 32'h10, 32'hDEAD_BEEF, 4'hF);
        cyc();
        cyc();
        settle();
        check("rst_grant", grant, '0);
        check("rst_valid_ready", {m_aw_valid, m_w_valid, m_b_ready, s_aw_ready, s_w_ready, s_b_valid}, '0);
        check("rst_payload", {m_aw_addr, m_w_data, m_w_strb, s_b_resp}, '0);
        rst       = 1'b0;
        m_b_valid = 1'b0;
        m_b_resp  = 2'b00;
        settle();
        check("idle_no_forward", {grant, m_aw_valid, m_w_valid}, '0);

        // Test 1: single write from m0
        serve(0, 2'b00, 1'b0);

        // Test 2: m0 and m1 together after reset, alternating ownership
        do_reset();
        m_aw_ready = 1'b1;
        m_w_ready  = 1'b1;
        raise(0, 32'h100, 32'h1111_0000, 4'hF);
        raise(1, 32'h200, 32'h2222_0000, 4'h3);
        serve(0, 2'b00, 1'b1);
        serve(1, 2'b00, 1'b1);
        serve(0, 2'b00, 1'b0);
        serve(1, 2'b00, 1'b0);

        // Test 3: W leads AW by 4 cycles; slave AW ready held off 3 cycles; early B from slave ignored
        aw0        = n_aw_hs;
        w0         = n_w_hs;
        m_aw_ready = 1'b0;
        m_w_ready  = 1'b1;
        m_b_valid  = 1'b1;
        m_b_resp   = 2'b00;
        s_b_ready  = 3'b010;
        ma_addr[1] = 32'h0000_0300;
        ma_data[1] = 32'hCAFE_F00D;
        ma_strb[1] = 4'hC;
        s_w_valid[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            settle();
            check("t3_w_not_request", {grant, m_w_valid, s_b_valid}, '0);
        end
        s_aw_valid[1] = 1'b1;
        cyc();
        settle();
        check("t3_grant", grant, 3'b010);
        check("t3_w_ready", s_w_ready, 3'b010);
        check("t3_aw_held", {s_aw_ready, m_aw_valid, m_b_ready}, {3'b000, 1'b1, 1'b0});
        cyc();
        s_w_valid[1] = 1'b0;
        settle();
        check("t3_w_done", {s_w_ready, s_b_valid, m_b_ready, m_aw_valid}, {3'b000, 3'b000, 1'b0, 1'b1});
        cyc();
        m_aw_ready = 1'b1;
        settle();
        check("t3_aw_ready", {s_aw_ready, m_b_ready}, {3'b010, 1'b0});
        cyc();
        s_aw_valid[1] = 1'b0;
        settle();
        check("t3_resp", {s_b_valid, m_b_ready}, {3'b010, 1'b1});
        cyc();
        m_b_valid = 1'b0;
        s_b_ready = '0;
        settle();
        check("t3_release", grant, '0);
        check("t3_one_aw_hs", n_aw_hs - aw0, 1);
        check("t3_one_w_hs", n_w_hs - w0, 1);

        // Test 4: master stalls B for 5 cycles while m1 waits
        m_w_ready = 1'b1;
        raise(0, 32'h400, 32'h4444_4444, 4'hF);
        raise(1, 32'h520, 32'h5555_5555, 4'h1);
        cyc();
        settle();
        check("t4_grant", grant, 3'b001);
        cyc();
        s_aw_valid[0] = 1'b0;
        s_w_valid[0]  = 1'b0;
        m_b_valid     = 1'b1;
        m_b_resp      = 2'b00;
        s_b_ready     = '0;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("t4_stall_m_b_ready", m_b_ready, 1'b0);
            check("t4_stall_grant", grant, 3'b001);
            check("t4_stall_b_valid", s_b_valid, 3'b001);
            check("t4_m1_pending", s_aw_ready, 3'b000);
            cyc();
        end
        s_b_ready[0] = 1'b1;
        settle();
        check("t4_b_ready", m_b_ready, 1'b1);
        cyc();
        m_b_valid = 1'b0;
        s_b_ready = '0;
        settle();
        check("t4_release", grant, '0);

        // Test 5: SLVERR passed through to m1
        serve(1, 2'b10, 1'b0);

        // Test 6: reset while m1 is mid-transfer
        raise(0, 32'h600, 32'h6666_6666, 4'hF);
        serve(0, 2'b00, 1'b0);
        raise(0, 32'h700, 32'h7777_7777, 4'hF);
        raise(1, 32'h800, 32'h8888_8888, 4'hF);
        m_aw_ready = 1'b0;
        m_w_ready  = 1'b0;
        cyc();
        settle();
        check("t6_grant_before_rst", grant, 3'b010);
        rst = 1'b1;
        cyc();
        settle();
        check("t6_rst_grant", grant, '0);
        check("t6_rst_outputs", {m_aw_valid, m_w_valid, m_b_ready, s_aw_ready, s_w_ready, s_b_valid}, '0);
        rst = 1'b0;
        cyc();
        settle();
        check("t6_regrant_m0", grant, 3'b001);

        // Randomized batches against the round-robin reference model
        do_reset();
        mlast = N - 1;
        for (int b = 0; b < 30; b++) begin
            rmask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if (rmask[i]) begin
                    ma_addr[i]    = $urandom & 32'hFFFF_FFFC;
                    ma_data[i]    = $urandom;
                    ma_strb[i]    = SW'($urandom_range(0, 15));
                    wwait[i]      = $urandom_range(0, 3);
                    s_aw_valid[i] = 1'b1;
                end
            end
            rpend = rmask;
            while (rpend != '0) begin
                for (int k = 1; k <= N; k++) begin
                    rj = (mlast + k) % N;
                    if (rpend[rj]) begin
                        exp_q.push_back(make_rec(rj));
                        rpend[rj] = 1'b0;
                        mlast     = rj;
                        break;
                    end
                end
            end
            rdone  = '0;
            sl_aw  = 1'b0;
            sl_w   = 1'b0;
            sl_dly = 0;
            cycles = 0;
            while (rdone != rmask && cycles < 300) begin
                for (int i = 0; i < N; i++) begin
                    if (rmask[i] && !rdone[i]) begin
                        if (s_aw_valid[i] || s_b_ready[i] || wwait[i] >= 0) begin
                            if (wwait[i] == 0) s_w_valid[i] = 1'b1;
                            if (wwait[i] >= 0) wwait[i]--;
                        end
                        s_b_ready[i] = 1'($urandom_range(0, 1));
                    end
                end
                m_aw_ready = 1'($urandom_range(0, 1));
                m_w_ready  = 1'($urandom_range(0, 1));
                if (sl_aw && sl_w && !m_b_valid) begin
                    if (sl_dly == 0) begin
                        m_b_valid = 1'b1;
                        m_b_resp  = cap_addr[5:4];
                    end else begin
                        sl_dly--;
                    end
                end
                settle();
                check("rand_owner_only", {$onehot0(grant), ~grant & (s_aw_ready | s_w_ready | s_b_valid)}, {1'b1, {N{1'b0}}});
                hs_aw = s_aw_valid & s_aw_ready;
                hs_w  = s_w_valid & s_w_ready;
                hs_b  = s_b_valid & s_b_ready;
                mhs_b = m_b_valid && m_b_ready;
                if (m_aw_valid && m_aw_ready) begin
                    cap_addr = m_aw_addr;
                    sl_aw    = 1'b1;
                    sl_dly   = $urandom_range(0, 2);
                end
                if (m_w_valid && m_w_ready) begin
                    cap_data = m_w_data;
                    cap_strb = m_w_strb;
                    sl_w     = 1'b1;
                end
                for (int i = 0; i < N; i++) begin
                    if (hs_b[i]) begin
                        exp_rec = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                        check("rand_write_record", {8'(i), cap_addr, cap_data, cap_strb, s_b_resp}, exp_rec);
                        rdone[i] = 1'b1;
                    end
                end
                cyc();
                for (int i = 0; i < N; i++) begin
                    if (hs_aw[i]) s_aw_valid[i] = 1'b0;
                    if (hs_w[i]) s_w_valid[i] = 1'b0;
                    if (hs_b[i]) s_b_ready[i] = 1'b0;
                end
                if (mhs_b) begin
                    m_b_valid = 1'b0;
                    sl_aw     = 1'b0;
                    sl_w      = 1'b0;
                end
                cycles++;
            end
            check("rand_batch_complete", rdone, rmask);
            if (rdone != rmask) begin
                exp_q.delete();
                do_reset();
                mlast = N - 1;
            end
        end
        check("rand_queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
